matrix_uart_formatter: RTL and testbench

Parametrised successor to the single-digit display engine. It reads a rows×cols matrix from storage in row-major order and renders each element as a variable-length decimal number, optionally signed. Elements in a row are separated by spaces and each row ends with a configurable line terminator. Output is a byte stream with a valid/ready handshake into the shared UART TX wrapper. It sits between the control FSM, the storage read MUX and the UART byte path.

---
 rtl/matrix_uart_formatter.sv | 195 +++++++++++++++++++
 tb/tb_matrix_uart_formatter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_uart_formatter.sv
// Streams a rows x cols storage matrix as decimal ASCII text (space separated, one line per row)
// over a registered valid/ready byte port; one element is read, converted and emitted at a time.
module matrix_uart_formatter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int ELEM_W  = 8,
  parameter int DIM_W   = 3,
  parameter int MAX_DIM = 5,
  parameter int RD_LAT  = 1,
  parameter int CRLF    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Decimal digits needed for the largest unsigned ELEM_W-bit value.
  function automatic int num_digits(input int w);
    longint v;
    int     n;
    v = (longint'(1) << w) - 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (v != 0) begin
        n++;
        v = v / 10;
      end
    end
    return n;
  endfunction

  localparam int NDIG = num_digits(ELEM_W);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int NBUF = 1 << IW;
  localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RD, S_CONV, S_EMIT, S_SEP, S_CR, S_LF, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              sm_q;
  logic [ADDR_W-1:0] base_q;
  logic [DIM_W-1:0]  rows_q, cols_q, r, c;
  logic [1:0]        rd_cnt;
  logic              neg_pend;
  logic [ELEM_W-1:0] elem, mag, quo;
  logic [31:0]       mag_w;
  logic [3:0]        digit;
  logic [3:0]        dig_buf [NBUF];
  logic [IW-1:0]     wr_idx, dig_idx;
  logic              dims_bad, rd_done, conv_last, last_col, last_row, xfer;
  logic              elem_neg, tx_state;
  logic [7:0]        tx_byte;

  if (DATA_W > ELEM_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^mem_rdata[DATA_W-1:ELEM_W];
  end

  assign elem      = mem_rdata[ELEM_W-1:0];
  assign elem_neg  = sm_q & elem[ELEM_W-1];
  assign mag_w     = 32'(mag);
  assign digit     = 4'(mag_w % 32'd10);
  assign quo       = ELEM_W'(mag_w / 32'd10);
  assign conv_last = (mag_w < 32'd10);
  assign rd_done   = (rd_cnt == 2'(RD_LAT));
  assign dims_bad  = (rows_q == '0) || (cols_q == '0) ||
                     (32'(rows_q) > MAX_DIM) || (32'(cols_q) > MAX_DIM);
  assign last_col  = ((c + ONE_D) == cols_q);
  assign last_row  = ((r + ONE_D) == rows_q);
  assign xfer      = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CHECK;
      S_CHECK: state_nxt = dims_bad ? S_DONE : S_RD;
      S_RD:    if (rd_done) state_nxt = S_CONV;
      S_CONV:  if (conv_last) state_nxt = S_EMIT;
      S_EMIT:  if (xfer && !neg_pend && dig_idx == '0)
                 state_nxt = !last_col ? S_SEP : ((CRLF != 0) ? S_CR : S_LF);
      S_SEP:   if (xfer) state_nxt = S_RD;
      S_CR:    if (xfer) state_nxt = S_LF;
      S_LF:    if (xfer) state_nxt = last_row ? S_DONE : S_RD;
      S_DONE:  if (!start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    tx_state = (state == S_EMIT) || (state == S_SEP) || (state == S_CR) || (state == S_LF);
    tx_byte  = 8'h0A;
    case (state)
      S_EMIT:  tx_byte = neg_pend ? 8'h2D : (8'h30 + 8'(dig_buf[dig_idx]));
      S_SEP:   tx_byte = 8'h20;
      S_CR:    tx_byte = 8'h0D;
      default: tx_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sm_q      <= 1'b0;
      base_q    <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      r         <= '0;
      c         <= '0;
      rd_cnt    <= '0;
      neg_pend  <= 1'b0;
      mag       <= '0;
      wr_idx    <= '0;
      dig_idx   <= '0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NBUF; i++) dig_buf[i] <= '0;
    end else begin
      err    <= 1'b0;
      rd_cnt <= '0;
      case (state)
        S_IDLE: if (start) begin
          sm_q   <= signed_mode;
          base_q <= base_addr;
          rows_q <= rows;
          cols_q <= cols;
        end
        S_CHECK: if (dims_bad) begin
          err <= 1'b1;
        end else begin
          r        <= '0;
          c        <= '0;
          mem_addr <= base_q;
        end
        S_RD: if (rd_done) begin
          neg_pend <= elem_neg;
          mag      <= elem_neg ? (~elem + ELEM_W'(1)) : elem;
          wr_idx   <= '0;
        end else begin
          rd_cnt <= rd_cnt + 2'd1;
        end
        S_CONV: begin
          // Digits land LSB-first; the last written slot is where emission starts.
          dig_buf[wr_idx] <= digit;
          mag             <= quo;
          if (conv_last) dig_idx <= wr_idx;
          else           wr_idx  <= wr_idx + IW'(1);
        end
        S_EMIT: if (xfer) begin
          if (neg_pend)              neg_pend <= 1'b0;
          else if (dig_idx != '0)    dig_idx  <= dig_idx - IW'(1);
        end
        S_SEP: if (xfer) begin
          c        <= c + ONE_D;
          mem_addr <= mem_addr + ADDR_W'(1);
        end
        S_LF: if (xfer && !last_row) begin
          r        <= r + ONE_D;
          c        <= '0;
          mem_addr <= mem_addr + ADDR_W'(1);
        end
        default: ;
      endcase
      // A byte is loaded only when the port is empty, so the next one appears a cycle after a transfer.
      if (xfer) begin
        out_valid <= 1'b0;
      end else if (tx_state && !out_valid) begin
        out_valid <= 1'b1;
        out_data  <= tx_byte;
      end
    end
  end

endmodule

// File: tb/tb_matrix_uart_formatter.sv
// Two formatter instances (LF / 1-cycle read, CRLF / 2-cycle read) checked byte-by-byte against
// a string-level model of the printed matrix, with randomized matrices and consumer stalls.
module tb_matrix_uart_formatter;
  logic        clk, rst_n;
  logic        start [2];
  logic        signed_mode [2];
  logic [7:0]  base_addr [2];
  logic [2:0]  rows [2];
  logic [2:0]  cols [2];
  logic [7:0]  mem_addr [2];
  logic        out_valid [2];
  logic [7:0]  out_data [2];
  logic        busy [2];
  logic        done [2];
  logic        err [2];
  logic [31:0] mem [2][256];
  string       exp_s [2];
  string       rx_str [2];
  int          exp_pos [2];
  int          rmode [2];
  int          err_cyc [2];
  int          n_checks = 0;
  int          n_pass = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input bit ok, input string name, input string act, input string exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  task automatic checki(input bit ok, input string name, input int act, input int exp);
    check(ok, name, $sformatf("%0d", act), $sformatf("%0d", exp));
  endtask

  function automatic bit is_bad(input int nr, input int nc);
    return (nr < 1) || (nr > 5) || (nc < 1) || (nc > 5);
  endfunction

  // Whole expected text of one run, built with plain integer formatting.
  function automatic string model_str(input int g, input bit sm, input logic [7:0] base,
                                      input int nr, input int nc);
    string s;
    logic [7:0] a, e;
    int v;
    s = "";
    if (is_bad(nr, nc)) return s;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        a = 8'(int'(base) + r * nc + c);
        e = mem[g][a][7:0];
        v = sm ? int'($signed(e)) : int'(e);
        s = {s, $sformatf("%0d", v)};
        if (c < nc - 1)  s = {s, " "};
        else if (g == 1) s = {s, "\r\n"};
        else             s = {s, "\n"};
      end
    end
    return s;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    logic [31:0] p1, p2, rdata;
    logic        rdy;

    matrix_uart_formatter #(
      .ADDR_W(8), .DATA_W(32), .ELEM_W(8), .DIM_W(3), .MAX_DIM(5), .RD_LAT(g + 1), .CRLF(g)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .signed_mode(signed_mode[g]),
      .base_addr(base_addr[g]), .rows(rows[g]), .cols(cols[g]), .mem_addr(mem_addr[g]),
      .mem_rdata(rdata), .out_valid(out_valid[g]), .out_data(out_data[g]), .out_ready(rdy),
      .busy(busy[g]), .done(done[g]), .err(err[g])
    );

    always @(posedge clk) begin
      p1 <= mem[g][mem_addr[g]];
      p2 <= p1;
    end
    assign rdata = (g == 0) ? p1 : p2;

    // Consumer: decides ready for the next edge, checks held bytes and every accepted byte.
    initial begin : mon
      bit         held;
      int         stall;
      logic [7:0] hd, e;
      held = 0; stall = 0; hd = '0; rdy = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          held = 0; stall = 0; rdy = 1'b0;
        end else begin
          if (err[g]) err_cyc[g]++;
          if (held)
            check(out_valid[g] && out_data[g] == hd, $sformatf("lane%0d hold", g),
                  $sformatf("v=%0b d=%02h", out_valid[g], out_data[g]), $sformatf("v=1 d=%02h", hd));
          if (out_valid[g]) begin
            if (!held && rmode[g] == 2) stall = 5;
            if (rmode[g] == 0)      rdy = 1'b1;
            else if (rmode[g] == 1) rdy = 1'($urandom_range(0, 1));
            else if (stall > 0) begin rdy = 1'b0; stall--; end
            else                    rdy = 1'b1;
            if (rdy) begin
              if (exp_pos[g] >= exp_s[g].len()) begin
                checki(0, $sformatf("lane%0d extra_byte", g), int'(out_data[g]), -1);
              end else begin
                e = exp_s[g][exp_pos[g]];
                exp_pos[g]++;
                check(out_data[g] == e, $sformatf("lane%0d byte%0d", g, exp_pos[g] - 1),
                      $sformatf("%02h", out_data[g]), $sformatf("%02h", e));
              end
              rx_str[g] = {rx_str[g], $sformatf("%c", out_data[g])};
              held = 0;
            end else begin
              held = 1;
              hd   = out_data[g];
            end
          end else begin
            rdy  = 1'($urandom_range(0, 1));
            held = 0;
          end
        end
      end
    end
  end

  task automatic arm(input int g, input bit sm, input logic [7:0] base, input int nr,
                     input int nc, input int mode);
    exp_s[g]   = model_str(g, sm, base, nr, nc);
    exp_pos[g] = 0;
    rx_str[g]  = "";
    err_cyc[g] = 0;
    rmode[g]   = mode;
    @(negedge clk);
    signed_mode[g] = sm;
    base_addr[g]   = base;
    rows[g]        = 3'(nr);
    cols[g]        = 3'(nc);
    start[g]       = 1'b1;
  endtask

  task automatic finish_run(input int g, input bit bad);
    int cyc;
    cyc = 0;
    while (!done[g] && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checki(done[g] == 1'b1, $sformatf("lane%0d done_wait_cycles", g), cyc, 5000);
    if (bad) checki(cyc <= 3, $sformatf("lane%0d bad_dim_done_latency", g), cyc, 3);
    repeat (3) @(negedge clk);
    checki(done[g] && busy[g] && !out_valid[g], $sformatf("lane%0d done_held_no_retrigger", g),
           int'({done[g], busy[g], out_valid[g]}), 3'b110);
    start[g] = 1'b0;
    @(negedge clk);
    checki(!done[g] && !busy[g], $sformatf("lane%0d back_to_idle", g),
           int'({done[g], busy[g]}), 0);
    checki(exp_pos[g] == exp_s[g].len(), $sformatf("lane%0d byte_count", g),
           exp_pos[g], exp_s[g].len());
    checki(err_cyc[g] == (bad ? 1 : 0), $sformatf("lane%0d err_cycles", g),
           err_cyc[g], bad ? 1 : 0);
  endtask

  task automatic run(input int g, input bit sm, input logic [7:0] base, input int nr,
                     input int nc, input int mode);
    arm(g, sm, base, nr, nc, mode);
    finish_run(g, is_bad(nr, nc));
  endtask

  function automatic void load_t1();
    mem[0][0] = 32'd1;   mem[0][1] = 32'd23; mem[0][2] = 32'd255;
    mem[0][3] = 32'd0;   mem[0][4] = 32'd7;  mem[0][5] = 32'd100;
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int cyc;
    logic [19:0] rs;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; signed_mode[g] = 1'b0; base_addr[g] = '0; rows[g] = '0; cols[g] = '0;
      exp_s[g] = ""; rx_str[g] = ""; exp_pos[g] = 0; rmode[g] = 0; err_cyc[g] = 0;
      for (int a = 0; a < 256; a++) mem[g][a] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      rs = {mem_addr[g], out_valid[g], out_data[g], busy[g], done[g], err[g]};
      checki(rs == '0, $sformatf("lane%0d reset_state", g), int'(rs), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Basic unsigned 2x3 matrix, consumer always ready.
    load_t1();
    check(model_str(0, 1'b0, 8'd0, 2, 3) == "1 23 255\n0 7 100\n", "model_pin_unsigned",
          "model text", "1 23 255 / 0 7 100");
    run(0, 1'b0, 8'd0, 2, 3, 0);
    check(rx_str[0] == "1 23 255\n0 7 100\n", "t1_text", $sformatf("len %0d", rx_str[0].len()),
          "1 23 255 / 0 7 100");
    checki(rx_str[0].len() == 17, "t1_len", rx_str[0].len(), 17);

    // Signed 1x3 with CRLF and junk above the element bits.
    mem[1][0] = 32'hABCD_00FF; mem[1][1] = 32'h1234_5680; mem[1][2] = 32'hFFFF_FF7F;
    check(model_str(1, 1'b1, 8'd0, 1, 3) == "-1 -128 127\r\n", "model_pin_signed",
          "model text", "-1 -128 127 CRLF");
    run(1, 1'b1, 8'd0, 1, 3, 1);
    check(rx_str[1] == "-1 -128 127\r\n", "t2_text", $sformatf("len %0d", rx_str[1].len()),
          "len 13");

    // 1x1 255 with 5-cycle stalls on every byte.
    mem[0][9] = 32'd255;
    run(0, 1'b0, 8'd9, 1, 1, 2);
    check(rx_str[0] == "255\n", "t3_text", $sformatf("len %0d", rx_str[0].len()), "255 LF");

    // Illegal dimensions.
    run(0, 1'b0, 8'd0, 0, 3, 0);
    run(1, 1'b0, 8'd0, 6, 1, 0);

    // Address wrap with 2-cycle read latency.
    mem[1][254] = 32'd5; mem[1][255] = 32'd66; mem[1][0] = 32'd200;
    run(1, 1'b0, 8'd254, 1, 3, 0);
    check(rx_str[1] == "5 66 200\r\n", "t5_text", $sformatf("len %0d", rx_str[1].len()), "len 10");
    checki(mem_addr[1] == 8'd0, "t5_final_addr", int'(mem_addr[1]), 0);

    // Reset while the second digit of 23 is waiting to go out.
    load_t1();
    arm(0, 1'b0, 8'd0, 2, 3, 2);
    cyc = 0;
    while (!(exp_pos[0] == 3 && out_valid[0]) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checki(cyc < 2000, "t6_reach_digit", cyc, 2000);
    rst_n = 1'b0;
    #1;
    checki(!out_valid[0] && !busy[0], "t6_async_reset", int'({out_valid[0], busy[0]}), 0);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 1'b0, 8'd0, 2, 3, 1);
    check(rx_str[0] == "1 23 255\n0 7 100\n", "t6_rerun_text",
          $sformatf("len %0d", rx_str[0].len()), "len 17");

    // Randomized matrices, data, bases, signedness and consumer behaviour.
    for (int i = 0; i < 12; i++) begin
      for (int g = 0; g < 2; g++) begin
        int nr, nc;
        for (int a = 0; a < 256; a++) mem[g][a] = $urandom;
        nr = $urandom_range(1, 5);
        nc = $urandom_range(1, 5);
        if (i % 5 == 4) nr = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(6, 7));
        run(g, 1'($urandom_range(0, 1)), 8'($urandom), nr, nc, $urandom_range(0, 2));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
